// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the Ex-stage control and the multi-cycle mul/div sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, lhs, rhs, flush,
    input  busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, lhs, rhs, flush,
    output busy, stall, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative mult/multu/div/divu unit: one shift-add or restoring-divide step per cycle,
// magnitudes in the loop and sign correction in a single FIX cycle before HI/LO are written.
//
// state | meaning
// IDLE  | waiting for an accepted start
// CALC  | one datapath step per cycle, WIDTH steps
// FIX   | sign correction, HI/LO written on exit
// DONE  | one-cycle done pulse
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic               is_div, sign_a, sign_b, dbz_q;
  logic [WIDTH-1:0]   mag_b, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               accept, rhs_zero, op_signed;
  logic [WIDTH-1:0]   lhs_mag, rhs_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign rhs_zero  = (bus.rhs == '0);
  assign op_signed = ~bus.op[0];
  assign lhs_mag   = (op_signed && bus.lhs[WIDTH-1]) ? -bus.lhs : bus.lhs;
  assign rhs_mag   = (op_signed && bus.rhs[WIDTH-1]) ? -bus.rhs : bus.rhs;

  // acc holds {product_hi, multiplier} for mult and {remainder, dividend} for div
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, mag_b} & {(WIDTH+1){acc[0]}});
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, mag_b});
    rem_diff = rem_sh[WIDTH-1:0] - mag_b;
    acc_step = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      acc_step = rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
    end
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (bus.op[1] && rhs_zero) ? DONE : CALC;
      CALC: begin
        if (bus.flush)       state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = FIX;
      end
      FIX:     state_nxt = bus.flush ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dbz_q  <= 1'b0;
      mag_b  <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_div <= bus.op[1];
            sign_a <= op_signed & bus.lhs[WIDTH-1];
            sign_b <= op_signed & bus.rhs[WIDTH-1];
            mag_b  <= rhs_mag;
            acc    <= {{WIDTH{1'b0}}, lhs_mag};
            cnt    <= CW'(WIDTH-1);
            dbz_q  <= bus.op[1] & rhs_zero;
            if (bus.op[1] && rhs_zero) begin
              hi_q <= bus.lhs;
              lo_q <= '1;
            end
          end
        end
        CALC: begin
          if (!bus.flush) begin
            acc <= acc_step;
            if (cnt != '0) cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (!bus.flush) begin
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == CALC) || (state == FIX);
  assign bus.stall       = accept || bus.busy;
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
